// File: rtl/f2f_out_packer.sv
// f2f_out_packer
//   Buffers DATAIN-bit result words in a small circular FIFO and serialises
//   each one MSB-first into DATAOUT-bit writes. The downstream `full` signal
//   throttles the writes. A word that arrives while the buffer is full, with
//   no pop in the same cycle, is dropped and sets the sticky `overflow` flag.
//
//   Optional feature: define F2F_PACK_CRC_EN to append one CRC-8 byte to
//   every word. The CRC uses poly 0x07, init 0, no reflection and no final
//   XOR, and covers the word's data bytes.
//
// Ports
//   clk       : clock, rising edge
//   rstn      : synchronous active-low reset
//   datain    : result word, valid with wren_in
//   wren_in   : one-cycle write strobe, one word per high cycle
//   full      : downstream byte FIFO full (back-pressure)
//   dataout   : output byte (registered, holds when wren=0)
//   wren      : output byte strobe (registered)
//   level     : words waiting in the buffer (excludes the word in the shifter)
//   overflow  : sticky drop flag, cleared only by reset
//   busy      : shifter loaded or buffer non-empty
module f2f_out_packer #(
  parameter int DATAIN  = 48,
  parameter int DATAOUT = 8,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [DATAIN-1:0]        datain,
  input  logic                     wren_in,
  input  logic                     full,
  output logic [DATAOUT-1:0]       dataout,
  output logic                     wren,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int N  = DATAIN / DATAOUT;
`ifdef F2F_PACK_CRC_EN
  localparam int LAST = N;      // the extra index carries the CRC byte
`else
  localparam int LAST = N - 1;
`endif
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [DATAIN-1:0]  mem [DEPTH];
  logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  state_t             state_q;
  logic [DATAIN-1:0]  shift_q;
  logic [CW-1:0]      cnt_q;
  logic [DATAOUT-1:0] dataout_q;
  logic               wren_q;
  logic               ovf_q;
  logic               buf_empty, buf_full, last_byte, pop, push;
  logic [DATAOUT-1:0] cur_byte, out_byte;

`ifdef F2F_PACK_CRC_EN
  logic [DATAOUT-1:0] crc_q, crc_nxt;

  function automatic logic [DATAOUT-1:0] crc_upd(input logic [DATAOUT-1:0] c,
                                                 input logic [DATAOUT-1:0] b);
    logic [DATAOUT-1:0] r;
    r = c ^ b;
    for (int i = 0; i < DATAOUT; i++)
      r = r[DATAOUT-1] ? ((r << 1) ^ DATAOUT'(7)) : (r << 1);
    return r;
  endfunction
`endif

  always_comb begin
    buf_empty = (wptr_q == rptr_q);
    // Same slot, opposite wrap bit: the buffer holds DEPTH words.
    buf_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    last_byte = (state_q == SHIFT) && !full && (cnt_q == LAST_CNT);
    // Reload from the buffer when idle, or back-to-back on the last byte.
    pop       = !buf_empty && ((state_q == IDLE) || last_byte);
    // A push into a full buffer is accepted only if a pop frees a slot now.
    push      = wren_in && (!buf_full || pop);
    wptr_d    = wptr_q + {{AW{1'b0}}, push};
    rptr_d    = rptr_q + {{AW{1'b0}}, pop};
    cur_byte  = shift_q[DATAIN-1 -: DATAOUT];
`ifdef F2F_PACK_CRC_EN
    crc_nxt   = crc_upd(crc_q, cur_byte);
    out_byte  = (cnt_q == LAST_CNT) ? crc_q : cur_byte;
`else
    out_byte  = cur_byte;
`endif
  end

  // Buffer storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= datain;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      dataout_q <= '0;
      wren_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef F2F_PACK_CRC_EN
      crc_q     <= '0;
`endif
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (wren_in && !push) ovf_q <= 1'b1;
      wren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem[rptr_q[AW-1:0]];
            cnt_q   <= '0;
`ifdef F2F_PACK_CRC_EN
            crc_q   <= '0;
`endif
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // While full is high, the shifter, counter and CRC all hold.
          if (!full) begin
            wren_q    <= 1'b1;
            dataout_q <= out_byte;
            if (cnt_q == LAST_CNT) begin
              if (pop) begin
                shift_q <= mem[rptr_q[AW-1:0]];
                cnt_q   <= '0;
`ifdef F2F_PACK_CRC_EN
                crc_q   <= '0;
`endif
              end else begin
                state_q <= IDLE;
              end
            end else begin
              shift_q <= shift_q << DATAOUT;
              cnt_q   <= cnt_q + CW'(1);
`ifdef F2F_PACK_CRC_EN
              crc_q   <= crc_nxt;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dataout  = dataout_q;
  assign wren     = wren_q;
  assign level    = wptr_q - rptr_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == SHIFT) || !buf_empty;

endmodule

// File: tb/tb_f2f_out_packer.sv
module tb_f2f_out_packer;
`ifdef F2F_PACK_CRC_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [47:0] datain = '0;
  logic        wren_in = 1'b0;
  logic        full = 1'b0;
  logic [7:0]  dataout;
  logic        wren;
  logic [2:0]  level;
  logic        overflow;
  logic        busy;

  f2f_out_packer #(.DATAIN(48), .DATAOUT(8), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .datain(datain), .wren_in(wren_in), .full(full),
    .dataout(dataout), .wren(wren), .level(level), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte capture with the cycle number of the edge that registered it.
  logic [7:0] q_b[$];
  int         q_c[$];
  always @(negedge clk) if (wren === 1'b1) begin
    q_b.push_back(dataout);
    q_c.push_back(cyc);
  end

  int npass = 0, ntot = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic logic [55:0] exp_word(input logic [47:0] w);
`ifdef F2F_PACK_CRC_EN
    logic [7:0] c;
    c = 8'h00;
    for (int j = 0; j < 6; j++) c = crc_upd(c, w[47-8*j -: 8]);
    return {w, c};
`else
    return {8'h00, w};
`endif
  endfunction

  function automatic logic [55:0] obs_word(input int base);
    logic [55:0] r;
    r = '0;
    for (int j = 0; j < NB; j++)
      r = {r[47:0], (base + j < q_b.size()) ? q_b[base+j] : 8'hxx};
    return r;
  endfunction

  function automatic logic [47:0] mkw(input int i);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 6; j++) r = {r[39:0], 8'(16 * (i + 1) + j)};
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [47:0] w);
    datain = w; wren_in = 1'b1;
    tick(1);
    wren_in = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
  endtask

  initial begin
    int t0;
    logic [55:0] e;
    tick(3);
    chk("rst_dataout", dataout, 0);
    chk("rst_wren", wren, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    tick(1);

    // Single word, no back-pressure
    q_b.delete(); q_c.delete();
    push(48'h0123456789AB); t0 = cyc;
    chk("t1_level_push", level, 1);
    chk("t1_busy_push", busy, 1);
    tick(1);
    chk("t1_level_load", level, 0);
    tick(NB + 4);
    chk("t1_count", q_b.size(), NB);
    chk("t1_word", obs_word(0), exp_word(48'h0123456789AB));
    chk("t1_first_cyc", q_c[0], t0 + 2);
    chk("t1_last_cyc", q_c[NB-1], t0 + NB + 1);
    e = exp_word(48'h0123456789AB);
    chk("t1_dataout_hold", dataout, e[7:0]);
    chk("t1_level_end", level, 0);
    chk("t1_busy_end", busy, 0);

    // full high for 3 cycles over the third byte
    q_b.delete(); q_c.delete();
    push(48'hA1B2C3D4E5F6); t0 = cyc;
    tick(3); full = 1'b1;
    tick(3); full = 1'b0;
    tick(NB + 3);
    chk("t2_count", q_b.size(), NB);
    chk("t2_word", obs_word(0), exp_word(48'hA1B2C3D4E5F6));
    chk("t2_b1_cyc", q_c[1], t0 + 3);
    chk("t2_b2_cyc", q_c[2], t0 + 7);
    chk("t2_last_cyc", q_c[NB-1], t0 + NB + 4);

    // Overflow: six pushes with full held high
    do_reset();
    q_b.delete(); q_c.delete();
    full = 1'b1;
    for (int i = 0; i < 6; i++) push(mkw(i));
    tick(1);
    chk("t3_level_full", level, 4);
    chk("t3_overflow", overflow, 1);
    chk("t3_no_bytes", q_b.size(), 0);
    full = 1'b0;
    tick(5 * NB + 5);
    chk("t3_count", q_b.size(), 5 * NB);
    for (int i = 0; i < 5; i++) chk($sformatf("t3_word%0d", i), obs_word(i * NB), exp_word(mkw(i)));
    chk("t3_overflow_sticky", overflow, 1);
    chk("t3_busy_end", busy, 0);

    // Push into full buffer on the final byte: accepted, no bubble
    do_reset();
    chk("t4_overflow_rst", overflow, 0);
    q_b.delete(); q_c.delete();
    full = 1'b1;
    for (int i = 0; i < 5; i++) push(mkw(i + 8));
    t0 = cyc;
    full = 1'b0;
    tick(NB - 1);
    datain = mkw(13); wren_in = 1'b1;
    tick(1);
    wren_in = 1'b0;
    chk("t4_overflow", overflow, 0);
    chk("t4_level", level, 4);
    tick(6 * NB + 4);
    chk("t4_count", q_b.size(), 6 * NB);
    chk("t4_next_cyc", q_c[NB], t0 + NB + 1);
    chk("t4_last_cyc", q_c[6*NB-1], t0 + 6 * NB);
    for (int i = 0; i < 6; i++) chk($sformatf("t4_word%0d", i), obs_word(i * NB), exp_word(mkw(i + 8)));

    // Reset mid-word after the third byte
    do_reset();
    q_b.delete(); q_c.delete();
    push(48'h1122334455_66); t0 = cyc;
    push(48'h778899AABBCC);
    tick(3);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    chk("t5_wren", wren, 0);
    chk("t5_dataout", dataout, 0);
    chk("t5_level", level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_partial", q_b.size(), 3);
    q_b.delete(); q_c.delete();
    tick(10);
    chk("t5_silent", q_b.size(), 0);
    push(48'hDEADBEEFCAFE); t0 = cyc;
    tick(NB + 4);
    chk("t5_count", q_b.size(), NB);
    chk("t5_word", obs_word(0), exp_word(48'hDEADBEEFCAFE));
    chk("t5_first_cyc", q_c[0], t0 + 2);

`ifdef F2F_PACK_CRC_EN
    q_b.delete(); q_c.delete();
    push(48'h000000000001);
    push(48'h000000000000);
    tick(2 * NB + 5);
    chk("crc_one", obs_word(0), 56'h00000000000107);
    chk("crc_zero", obs_word(NB), 56'h00000000000000);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/f2f_out_packer.md
# f2f_out_packer

Downstream stage of the float/fixed conversion datapath. It accepts 48-bit result words, each with a single-cycle write strobe, from the conversion top level and buffers them in a small word FIFO. It serialises each word MSB-first into 8-bit writes toward the byte-wide output FIFO and honours that FIFO's `full` back-pressure. Words that arrive while the buffer is full are dropped and flagged.

## Interface
Parameters:
- `DATAIN`, 48, input word width; must be a multiple of `DATAOUT`.
- `DATAOUT`, 8, output byte width.
- `DEPTH`, 4, word-buffer entries; power of two, minimum 2.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `datain` in `DATAIN`: result word; valid when `wren_in`=1.
- `wren_in` in 1: one-cycle write strobe; one word per high cycle.
- `full` in 1: downstream byte FIFO full.
- `dataout` out `DATAOUT`: output byte, registered.
- `wren` out 1: output byte strobe, registered, high for one cycle per byte.
- `level` out clog2(`DEPTH`)+1: words held in the buffer, excluding the word being shifted.
- `overflow` out 1: sticky; set when a word is dropped; cleared only by reset.
- `busy` out 1: high while a word is in the shifter or the buffer is non-empty.

## Operation
- Word buffer is a circular FIFO of `DEPTH` entries with read and write pointers that carry one extra wrap bit.
  - Push on `wren_in`=1 if not full.
  - Push on `wren_in`=1 while full is allowed only if a pop happens in the same cycle; the push then succeeds.
  - Otherwise the word is discarded, `overflow` is set, and the pointers are unchanged.
- `N` = `DATAIN`/`DATAOUT` bytes per word (6 by default).
- FSM states:
  - IDLE: shifter empty. If buffer non-empty: pop into shift register, byte counter=0, go to SHIFT.
  - SHIFT: if `full`=0, drive `dataout` = shift[DATAIN-1 -: DATAOUT], `wren`=1, shift left by `DATAOUT`, increment counter. If `full`=1, `wren`=0 and the shifter and counter hold.
  - Last byte issued (counter=N-1, or CRC byte when enabled): if buffer non-empty, pop and reload in the same cycle and stay in SHIFT. Otherwise go to IDLE.
- Byte order: MSB first. `datain[47:40]` goes out first and `datain[7:0]` last.
- `dataout` holds its last value when `wren`=0.
- Reset values: `dataout`=0, `wren`=0, `level`=0, `overflow`=0, `busy`=0, FSM=IDLE, both pointers=0.
- Reset asserted mid-word: the partial word is abandoned, buffered words are lost, and no further `wren` pulses are produced.

## Timing
- Push at cycle T into an idle, empty block:
  - T+1: pop and load.
  - T+2: first `wren`, provided `full` was 0 at T+1 sampling.
  - T+2 … T+N+1: bytes issued on consecutive cycles with no back-pressure.
- Sustained throughput: one word per N cycles when buffered words are back-to-back (no IDLE bubble).
- `full` is sampled every SHIFT cycle. A byte is issued only in a cycle whose sampled `full` is 0. No byte is lost or duplicated.
- `level` and `overflow` update the cycle after the causing event.
- Push and pop in the same cycle: `level` is unchanged.

## Configuration
- `F2F_PACK_CRC_EN` defined:
  - After the N data bytes, one extra byte is emitted: CRC-8 over those N bytes, polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Word framing is N+1 bytes. The CRC byte obeys `full` like any data byte.
- Not defined: exactly N bytes per word; no CRC logic is synthesised.

## Test plan
- Single word 0x0123456789AB, `full`=0 → bytes 01,23,45,67,89,AB on six consecutive cycles starting 2 cycles after the push; `level` returns to 0 and `busy`=0 afterward.
- `full` held high for 3 cycles mid-word (during the third byte) → `wren` is low for those 3 cycles; the byte sequence is unchanged and complete with no repeats.
- Push 6 words back-to-back while `full`=1, `DEPTH`=4 → 1 word in the shifter and 4 buffered; the 6th word is dropped and `overflow`=1. After releasing `full`, exactly 5 words (30 bytes) come out, in order.
- Push on the same cycle as the final byte of a word with the buffer full → push accepted, `overflow` stays 0, and the next word starts on the following cycle with no bubble.
- `rstn`=0 for one cycle after the 3rd byte → `wren` low from the next cycle; all outputs at reset values; a subsequent word serialises cleanly from its first byte.
- With `F2F_PACK_CRC_EN`: word 0x000000000001 → 00,00,00,00,00,01,07. Word 0x000000000000 → six 00 bytes, then CRC 00.
